// File: rtl/cpu_clock_enable_ctrl.sv
// Clock-enable generator for the 6502 core: HALT / SLOW (1 Hz tick) / STEP (debounced button) / FAST (divided clock).
// Also provides a wrapping step counter and an activity LED for board debug.
module cpu_clock_enable_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int FAST_DIV        = 50
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        tick_in,
  input  logic        step_btn,
  input  logic [1:0]  mode,
  output logic        cpu_ce,
  output logic [15:0] step_count,
  output logic        btn_db,
  output logic        ce_led,
  output logic [1:0]  state_o
);

  localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
  localparam logic [15:0]     DIV_LAST = 16'(FAST_DIV - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_SLOW = 2'b01,
    ST_STEP = 2'b10,
    ST_FAST = 2'b11
  } state_e;

  logic            btn_s1_q, btn_s2_q;
  logic [1:0]      mode_s1_q, mode_s2_q;
  state_e          state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_db_q, btn_db_d;
  logic            btn_db_prev_q;
  logic [15:0]     div_q, div_d;
  logic            cpu_ce_q, cpu_ce_d;
  logic [15:0]     step_count_q, step_count_d;
  logic            ce_led_q, ce_led_d;
  logic            press_s;
  logic            fast_run_s;

  // Next-state logic for debounce, divider, clock enable and counters
  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (btn_s2_q != btn_db_q) begin
      if ((db_cnt_q + DB_ONE) == DB_LAST) begin
        btn_db_d = btn_s2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end else begin
      db_cnt_d = '0;
    end

    press_s = btn_db_q & ~btn_db_prev_q;

    // FAST also requires the incoming mode so no pulse lands in the first cycle after leaving FAST.
    fast_run_s = (state_q == ST_FAST) && (mode_s2_q == ST_FAST);

    div_d = 16'd0;
    if (fast_run_s) begin
      if (div_q == DIV_LAST) begin
        div_d = 16'd0;
      end else begin
        div_d = div_q + 16'd1;
      end
    end else begin
      div_d = 16'd0;
    end

    cpu_ce_d = 1'b0;
    case (state_q)
      ST_HALT: cpu_ce_d = 1'b0;
      ST_SLOW: cpu_ce_d = tick_in;
      ST_STEP: cpu_ce_d = press_s;
      ST_FAST: cpu_ce_d = fast_run_s && (div_q == DIV_LAST);
      default: cpu_ce_d = 1'b0;
    endcase

    step_count_d = step_count_q;
    ce_led_d     = ce_led_q;
    if (cpu_ce_q) begin
      step_count_d = step_count_q + 16'd1;
      ce_led_d     = ~ce_led_q;
    end else begin
      step_count_d = step_count_q;
      ce_led_d     = ce_led_q;
    end

    state_d = state_e'(mode_s2_q);
  end

  // Synchronizers, state register and all registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      btn_s1_q      <= 1'b0;
      btn_s2_q      <= 1'b0;
      mode_s1_q     <= 2'b00;
      mode_s2_q     <= 2'b00;
      state_q       <= ST_HALT;
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      div_q         <= 16'd0;
      cpu_ce_q      <= 1'b0;
      step_count_q  <= 16'd0;
      ce_led_q      <= 1'b0;
    end else begin
      btn_s1_q      <= step_btn;
      btn_s2_q      <= btn_s1_q;
      mode_s1_q     <= mode;
      mode_s2_q     <= mode_s1_q;
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      div_q         <= div_d;
      cpu_ce_q      <= cpu_ce_d;
      step_count_q  <= step_count_d;
      ce_led_q      <= ce_led_d;
    end
  end

  assign cpu_ce     = cpu_ce_q;
  assign step_count = step_count_q;
  assign btn_db     = btn_db_q;
  assign ce_led     = ce_led_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cpu_clock_enable_ctrl.sv
// Directed bench for cpu_clock_enable_ctrl: a per-cycle vector table plus hand-written button, reset and wrap sequences.
module tb_cpu_clock_enable_ctrl;

  logic        CLK;
  logic        RESET;
  logic        tick_in;
  logic        step_btn;
  logic [1:0]  mode;
  logic        cpu_ce;
  logic [15:0] step_count;
  logic        btn_db;
  logic        ce_led;
  logic [1:0]  state_o;

  logic [1:0]  mode1;
  logic        cpu_ce1;
  logic [15:0] step_count1;
  logic        btn_db1;
  logic        ce_led1;
  logic [1:0]  state1;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_clock_enable_ctrl #(.DEBOUNCE_CYCLES(4), .FAST_DIV(3)) dut (
    .CLK(CLK), .RESET(RESET), .tick_in(tick_in), .step_btn(step_btn), .mode(mode),
    .cpu_ce(cpu_ce), .step_count(step_count), .btn_db(btn_db), .ce_led(ce_led), .state_o(state_o)
  );

  // Second instance used only for the 16-bit wrap check (one pulse per cycle)
  cpu_clock_enable_ctrl #(.DEBOUNCE_CYCLES(4), .FAST_DIV(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .tick_in(1'b0), .step_btn(1'b0), .mode(mode1),
    .cpu_ce(cpu_ce1), .step_count(step_count1), .btn_db(btn_db1), .ce_led(ce_led1), .state_o(state1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  mode;
    logic        tick;
    logic        exp_ce;
    logic [1:0]  exp_st;
    logic [15:0] exp_cnt;
    logic        exp_led;
  } vec_t;

  vec_t tbl[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (state_o == s) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_state", {31'd0, hit}, 32'd1);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("no_ce", {31'd0, cpu_ce}, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_cnt;
    logic        hit;

    //            mode   tick  ce    st     cnt     led
    tbl[0]  = '{2'b01, 1'b0, 1'b0, 2'b00, 16'd0, 1'b0};
    tbl[1]  = '{2'b01, 1'b0, 1'b0, 2'b00, 16'd0, 1'b0};
    tbl[2]  = '{2'b01, 1'b0, 1'b0, 2'b01, 16'd0, 1'b0};
    tbl[3]  = '{2'b01, 1'b1, 1'b1, 2'b01, 16'd0, 1'b0};
    tbl[4]  = '{2'b01, 1'b0, 1'b0, 2'b01, 16'd1, 1'b1};
    tbl[5]  = '{2'b01, 1'b1, 1'b1, 2'b01, 16'd1, 1'b1};
    tbl[6]  = '{2'b01, 1'b1, 1'b1, 2'b01, 16'd2, 1'b0};
    tbl[7]  = '{2'b01, 1'b0, 1'b0, 2'b01, 16'd3, 1'b1};
    tbl[8]  = '{2'b10, 1'b0, 1'b0, 2'b01, 16'd3, 1'b1};
    tbl[9]  = '{2'b10, 1'b0, 1'b0, 2'b01, 16'd3, 1'b1};
    tbl[10] = '{2'b10, 1'b1, 1'b1, 2'b10, 16'd3, 1'b1};
    tbl[11] = '{2'b10, 1'b1, 1'b0, 2'b10, 16'd4, 1'b0};
    tbl[12] = '{2'b11, 1'b0, 1'b0, 2'b10, 16'd4, 1'b0};
    tbl[13] = '{2'b11, 1'b0, 1'b0, 2'b10, 16'd4, 1'b0};
    tbl[14] = '{2'b11, 1'b0, 1'b0, 2'b11, 16'd4, 1'b0};
    tbl[15] = '{2'b11, 1'b0, 1'b0, 2'b11, 16'd4, 1'b0};
    tbl[16] = '{2'b11, 1'b0, 1'b0, 2'b11, 16'd4, 1'b0};
    tbl[17] = '{2'b11, 1'b0, 1'b1, 2'b11, 16'd4, 1'b0};
    tbl[18] = '{2'b11, 1'b0, 1'b0, 2'b11, 16'd5, 1'b1};
    tbl[19] = '{2'b11, 1'b0, 1'b0, 2'b11, 16'd5, 1'b1};
    tbl[20] = '{2'b11, 1'b0, 1'b1, 2'b11, 16'd5, 1'b1};
    tbl[21] = '{2'b00, 1'b0, 1'b0, 2'b11, 16'd6, 1'b0};
    tbl[22] = '{2'b00, 1'b0, 1'b0, 2'b11, 16'd6, 1'b0};
    tbl[23] = '{2'b00, 1'b0, 1'b0, 2'b00, 16'd6, 1'b0};
    tbl[24] = '{2'b00, 1'b0, 1'b0, 2'b00, 16'd6, 1'b0};

    RESET    = 1'b1;
    tick_in  = 1'b0;
    step_btn = 1'b0;
    mode     = 2'b00;
    mode1    = 2'b00;
    repeat (3) step();
    check("rst_ce",    {31'd0, cpu_ce}, 32'd0);
    check("rst_count", {16'd0, step_count}, 32'd0);
    check("rst_btn_db",{31'd0, btn_db}, 32'd0);
    check("rst_led",   {31'd0, ce_led}, 32'd0);
    check("rst_state", {30'd0, state_o}, 32'd0);
    RESET = 1'b0;

    // SLOW ticks, coincident tick on SLOW->STEP, tick in STEP, FAST entry and exit
    for (int i = 0; i < 25; i++) begin
      mode    = tbl[i].mode;
      tick_in = tbl[i].tick;
      step();
      check($sformatf("vec%0d_ce", i),    {31'd0, cpu_ce},     {31'd0, tbl[i].exp_ce});
      check($sformatf("vec%0d_state", i), {30'd0, state_o},    {30'd0, tbl[i].exp_st});
      check($sformatf("vec%0d_count", i), {16'd0, step_count}, {16'd0, tbl[i].exp_cnt});
      check($sformatf("vec%0d_led", i),   {31'd0, ce_led},     {31'd0, tbl[i].exp_led});
    end
    tick_in = 1'b0;
    exp_cnt = 16'd6;

    // STEP: held press -> btn_db at raw+6, one pulse at raw+7
    mode = 2'b10;
    wait_state(2'b10);
    step_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("press_db_k%0d", k), {31'd0, btn_db}, {31'd0, (k >= 6)});
      check($sformatf("press_ce_k%0d", k), {31'd0, cpu_ce}, {31'd0, (k == 7)});
    end
    quiet(10);
    exp_cnt = exp_cnt + 16'd1;
    check("press_count", {16'd0, step_count}, {16'd0, exp_cnt});
    check("press_led",   {31'd0, ce_led}, 32'd1);

    step_btn = 1'b0;
    quiet(12);
    check("release_db",    {31'd0, btn_db}, 32'd0);
    check("release_count", {16'd0, step_count}, {16'd0, exp_cnt});

    // 3-cycle glitch must not be accepted
    step_btn = 1'b1;
    quiet(3);
    step_btn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check("glitch_ce", {31'd0, cpu_ce}, 32'd0);
      check("glitch_db", {31'd0, btn_db}, 32'd0);
    end

    // tick_in in STEP is discarded
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    quiet(3);
    check("tick_in_step_count", {16'd0, step_count}, {16'd0, exp_cnt});

    // Button press in SLOW is discarded, though debounce still tracks it
    mode = 2'b01;
    wait_state(2'b01);
    step_btn = 1'b1;
    quiet(20);
    check("slow_press_db", {31'd0, btn_db}, 32'd1);
    step_btn = 1'b0;
    quiet(12);
    check("slow_press_count", {16'd0, step_count}, {16'd0, exp_cnt});

    // FAST, then asynchronous reset while cpu_ce is high
    mode = 2'b11;
    wait_state(2'b11);
    hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cpu_ce) begin
        hit = 1'b1;
        break;
      end
    end
    check("fast_pulse_seen", {31'd0, hit}, 32'd1);
    check("fast_count_nz", {31'd0, (step_count != 16'd0)}, 32'd1);
    RESET = 1'b1;
    #2;
    check("async_rst_ce",    {31'd0, cpu_ce}, 32'd0);
    check("async_rst_count", {16'd0, step_count}, 32'd0);
    check("async_rst_led",   {31'd0, ce_led}, 32'd0);
    check("async_rst_state", {30'd0, state_o}, 32'd0);
    step();
    step();
    RESET = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("post_rst_ce_k%0d", k),    {31'd0, cpu_ce},  {31'd0, (k == 6)});
      check($sformatf("post_rst_state_k%0d", k), {30'd0, state_o}, (k >= 3) ? 32'd3 : 32'd0);
    end

    // 16-bit wrap on the FAST_DIV=1 instance
    mode  = 2'b00;
    mode1 = 2'b11;
    hit   = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      step();
      if (step_count1 == 16'hFFFF) begin
        hit = 1'b1;
        break;
      end
    end
    check("wrap_reached_ffff", {31'd0, hit}, 32'd1);
    check("wrap_ce_high",      {31'd0, cpu_ce1}, 32'd1);
    check("wrap_led_ffff",     {31'd0, ce_led1}, 32'd1);
    step();
    check("wrap_count_zero",   {16'd0, step_count1}, 32'd0);
    check("wrap_led_zero",     {31'd0, ce_led1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
